// File: rtl/uart_tx_arb_pkg.sv
// Shared encodings and defaults for the UART transmit arbiter.
// Optional frame tagging is enabled by defining UART_TX_ARB_TAG_EN.
package uart_tx_arb_pkg;

    localparam int         ARB_ID_W         = 3;
    localparam logic [7:0] TAG_BASE_DEF     = 8'hF0;
    localparam int         HOLD_TIMEOUT_DEF = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_HOLD,
        ST_TAG
    } arb_state_t;

    // Width of a counter that must reach the hold timeout value.
    function automatic int to_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority pick: first valid index strictly after ptr, wrapping.
// Purely combinational; outputs are zero when no input is valid.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ARB_ID_W-1:0] ptr,
    output logic [NUM_REQ-1:0]  pick,
    output logic [ARB_ID_W-1:0] pick_idx
);

    logic [7:0]          valid_ext;
    logic [ARB_ID_W-1:0] j;
    logic                found;

    assign valid_ext = 8'(valid);

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = ARB_ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && valid_ext[j]) begin
                found    = 1'b1;
                pick_idx = j;
            end
        end
        if (found) begin
            pick = NUM_REQ'(8'h01 << pick_idx);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked sharing of one UART byte transmitter among NUM_REQ requesters.
// Define UART_TX_ARB_TAG_EN to prefix every frame with tag byte TAG_BASE | requester id.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
`ifdef UART_TX_ARB_TAG_EN
    ,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 hold_abort
);

    localparam int                TO_W      = to_width(HOLD_TIMEOUT);
    localparam logic [TO_W-1:0]   HOLD_LAST = TO_W'(HOLD_TIMEOUT - 1);

    arb_state_t          state;
    logic [ARB_ID_W-1:0] rr_ptr;
    logic [ARB_ID_W-1:0] gidx;
    logic                last;
    logic [TO_W-1:0]     hold_cnt;

    logic [NUM_REQ-1:0]  pick_oh;
    logic [ARB_ID_W-1:0] pick_idx;
    logic [63:0]         data_ext;
    logic [7:0]          last_ext;
    logic [7:0]          valid_ext;

    assign data_ext  = 64'(req_data);
    assign last_ext  = 8'(req_last);
    assign valid_ext = 8'(req_valid);

    uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid    (req_valid),
        .ptr      (rr_ptr),
        .pick     (pick_oh),
        .pick_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= ARB_ID_W'(NUM_REQ - 1);
            gidx       <= '0;
            last       <= 1'b0;
            hold_cnt   <= '0;
            req_ready  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant      <= '0;
            hold_abort <= 1'b0;
        end else begin
            req_ready  <= '0;
            tx_start   <= 1'b0;
            hold_abort <= 1'b0;
            case (state)
                // A busy line (e.g. a byte still shifting out after reset) blocks arbitration.
                ST_IDLE: begin
                    if (|req_valid && !tx_busy) begin
                        grant <= pick_oh;
                        gidx  <= pick_idx;
`ifdef UART_TX_ARB_TAG_EN
                        state <= ST_TAG;
`else
                        req_ready <= pick_oh;
                        state     <= ST_ACCEPT;
`endif
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                ST_TAG: begin
                    tx_data  <= TAG_BASE | 8'(gidx);
                    last     <= 1'b0;
                    tx_start <= 1'b1;
                    state    <= ST_LAUNCH;
                end
`endif
                ST_ACCEPT: begin
                    tx_data  <= data_ext[{gidx, 3'b000} +: 8];
                    last     <= last_ext[gidx];
                    tx_start <= 1'b1;
                    state    <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (last) begin
                            rr_ptr <= gidx;
                            grant  <= '0;
                            state  <= ST_IDLE;
                        end else if (valid_ext[gidx]) begin
                            req_ready <= grant;
                            state     <= ST_ACCEPT;
                        end else begin
                            hold_cnt <= '0;
                            state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (valid_ext[gidx]) begin
                        req_ready <= grant;
                        state     <= ST_ACCEPT;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_abort <= 1'b1;
                        rr_ptr     <= gidx;
                        grant      <= '0;
                        state      <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a cycle-level transmitter model
// and a frame-level round-robin reference for the expected line byte stream.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int HT = 16;
    localparam int BT = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic [N-1:0]   grant;
    logic           hold_abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .grant      (grant),
        .hold_abort (hold_abort)
    );

    logic [8:0] rq [N][$];
    logic [7:0] line_q[$], exp_line[$];
    int         gnt_q[$], exp_gnt[$];
    logic [N-1:0] prev_grant = '0;
    int cyc = 0, busy_cnt = 0, last_fall = -100;
    int n_cmp = 0, n_fail = 0;
    int first_ready = -1, first_start = -1, start_gap = -1;
    int abort_n = 0, abort_gap = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = rq[i].size() > 0;
            req_data[8*i +: 8] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]       = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        logic         st;
        logic [7:0]   d;
        acc = req_valid & req_ready;
        st  = tx_start;
        d   = tx_data;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) void'(rq[i].pop_front());
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) last_fall = cyc;
        end
        if (st) begin
            line_q.push_back(d);
            busy_cnt = BT;
        end
        tx_busy = (busy_cnt != 0);
        drive();
        if (grant != '0 && grant != prev_grant) gnt_q.push_back(oh_idx(grant));
        prev_grant = grant;
        if (req_ready != '0 && first_ready < 0) first_ready = cyc;
        if (tx_start && first_start < 0) begin
            first_start = cyc;
            start_gap   = cyc - last_fall;
        end
        if (hold_abort) begin
            abort_n++;
            abort_gap = cyc - last_fall;
        end
        chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        chk("start_while_busy", 32'(tx_start & tx_busy), 32'd0);
    endtask

    function automatic bit all_done();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 1'b0;
        return e && grant == '0 && busy_cnt == 0 && !tx_start;
    endfunction

    task automatic run_until_idle(input string tag, input int budget);
        int k = 0;
        step();
        while (!all_done() && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) chk({tag, "_cycle_budget"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        int k = 0;
        for (int i = 0; i < N; i++) rq[i].delete();
        drive();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        while (busy_cnt > 0 && k < 100) begin step(); k++; end
        step();
        line_q.delete();
        gnt_q.delete();
        abort_n = 0;
    endtask

    // Frame-level round robin: each frame goes out whole, next owner is the
    // first nonempty requester after the previous owner.
    task automatic build_expect();
        logic [8:0] mq [N][$];
        logic [8:0] e;
        int ptr = N - 1;
        int sel;
        exp_line.delete();
        exp_gnt.delete();
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        forever begin
            sel = -1;
            for (int k = 1; k <= N; k++)
                if (sel < 0 && mq[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
            if (sel < 0) break;
            exp_gnt.push_back(sel);
`ifdef UART_TX_ARB_TAG_EN
            exp_line.push_back(8'hF0 | 8'(sel));
`endif
            do begin
                e = mq[sel].pop_front();
                exp_line.push_back(e[7:0]);
            end while (!e[8] && mq[sel].size() > 0);
            ptr = sel;
        end
    endtask

    task automatic cmp_logs(input string tag);
        chk({tag, "_nbytes"}, 32'(line_q.size()), 32'(exp_line.size()));
        for (int i = 0; i < line_q.size() && i < exp_line.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(line_q[i]), 32'(exp_line[i]));
        chk({tag, "_ngrants"}, 32'(gnt_q.size()), 32'(exp_gnt.size()));
        for (int i = 0; i < gnt_q.size() && i < exp_gnt.size(); i++)
            chk($sformatf("%s_grant%0d", tag, i), 32'(gnt_q[i]), 32'(exp_gnt[i]));
    endtask

    initial begin
        int c, k, nf, len;
        drive();

        // Reset values
        step();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_start", 32'(tx_start), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_abort", 32'(hold_abort), 32'd0);

        // Single byte, latency
        do_reset();
        rq[0].push_back({1'b1, 8'hA5});
        drive();
        c = cyc;
        first_ready = -1;
        first_start = -1;
        build_expect();
        run_until_idle("single", 300);
`ifndef UART_TX_ARB_TAG_EN
        chk("single_ready_lat", 32'(first_ready - c), 32'd1);
`endif
        chk("single_start_lat", 32'(first_start - c), 32'd2);
        chk("single_grant_idle", 32'(grant), 32'd0);
        cmp_logs("single");

        // Fairness: two 1-byte frames each
        do_reset();
        for (int i = 0; i < N; i++)
            for (int f = 0; f < 2; f++) rq[i].push_back({1'b1, 8'(8'h10 * i + f)});
        drive();
        build_expect();
        run_until_idle("fair", 1000);
        cmp_logs("fair");

        // Frame lock: req1 three bytes while req2 waits
        do_reset();
        rq[1].push_back({1'b0, 8'h31});
        rq[1].push_back({1'b0, 8'h32});
        rq[1].push_back({1'b1, 8'h33});
        rq[2].push_back({1'b1, 8'h44});
        drive();
        build_expect();
        run_until_idle("lock", 500);
        cmp_logs("lock");

        // Hold timeout: req3 stalls mid-frame, req0 waits behind it
        do_reset();
        rq[3].push_back({1'b0, 8'h3C});
        drive();
        k = 0;
        while (rq[3].size() > 0 && k < 100) begin step(); k++; end
        rq[0].push_back({1'b1, 8'h0F});
        drive();
        abort_gap = -1;
        run_until_idle("hold", 500);
        chk("hold_abort_count", 32'(abort_n), 32'd1);
        chk("hold_abort_time", 32'(abort_gap), 32'(HT + 1));
        chk("hold_ngrants", 32'(gnt_q.size()), 32'd2);
        if (gnt_q.size() == 2) begin
            chk("hold_first_owner", 32'(gnt_q[0]), 32'd3);
            chk("hold_next_owner", 32'(gnt_q[1]), 32'd0);
        end
        chk("hold_last_byte", 32'(line_q.size() > 0 ? line_q[line_q.size()-1] : 8'h00), 32'h0F);

        // Reset while waiting for busy to fall
        do_reset();
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h22});
        drive();
        k = 0;
        while (busy_cnt != BT - 3 && k < 200) begin step(); k++; end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_start", 32'(tx_start), 32'd0);
        chk("midrst_data", 32'(tx_data), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_abort", 32'(hold_abort), 32'd0);
        chk("midrst_line_busy", 32'(tx_busy), 32'd1);
        first_start = -1;
        start_gap = -1;
        run_until_idle("midrst", 500);
        chk("midrst_restart_gap", 32'(start_gap), 32'd2);

        // Randomized frames on all requesters
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        rq[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
                end
            end
            drive();
            build_expect();
            run_until_idle($sformatf("rand%0d", r), 3000);
            cmp_logs($sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
